// File: rtl/mac_rx_if.sv
// ---------------------------------------------------------------------------
// mac_rx_if : MII receive bus plus higher-layer result bus of the MAC receiver.
//
//   in_rxdv, in_rxd          MII-side byte stream into the receiver
//   out_rxen, out_rxd        payload byte stream towards the higher layer
//   out_hdr_valid            pulse: dest/src/type hold the current header
//   out_dest_mac, out_src_mac, out_ether_type   captured header fields
//   out_eof, out_frame_ok, out_err               end-of-frame status
//
// Modports:
//   master : side that feeds MII bytes and consumes the results
//   slave  : the receiver itself (mac_rx)
// ---------------------------------------------------------------------------
interface mac_rx_if;
   logic        in_rxdv;
   logic [7:0]  in_rxd;
   logic        out_rxen;
   logic [7:0]  out_rxd;
   logic        out_hdr_valid;
   logic [47:0] out_dest_mac;
   logic [47:0] out_src_mac;
   logic [15:0] out_ether_type;
   logic        out_eof;
   logic        out_frame_ok;
   logic [2:0]  out_err;

   modport master (
      output in_rxdv, in_rxd,
      input  out_rxen, out_rxd, out_hdr_valid, out_dest_mac, out_src_mac,
             out_ether_type, out_eof, out_frame_ok, out_err
   );

   modport slave (
      input  in_rxdv, in_rxd,
      output out_rxen, out_rxd, out_hdr_valid, out_dest_mac, out_src_mac,
             out_ether_type, out_eof, out_frame_ok, out_err
   );
endinterface

// File: rtl/mac_rx.sv
// ---------------------------------------------------------------------------
// mac_rx : receive side of the Ethernet MAC.
//
// Hunts preamble + SFD, captures destination MAC, source MAC and EtherType,
// forwards the payload with the 4 FCS bytes stripped by a 4-byte delay line,
// and reports frame status with a one-cycle end-of-frame pulse.
//
// Ports:
//   in_clk    clock, all logic on rising edge
//   in_rst_n  asynchronous reset, active-low
//   bus       mac_rx_if.slave (MII input bytes, payload/header/status out)
//
// Parameters:
//   MIN_PREAMBLE  0xAA bytes required before SFD 0xAB
//   MIN_PAYLOAD   payload size below which the frame is flagged short
//   MAX_PAYLOAD   payload size above which the frame is flagged long;
//                 forwarding stops once this many bytes have been sent
//
// Build option:
//   MAC_RX_FCS_CHECK_EN  when defined, a CRC-32 runs over dest..FCS and
//                        err[2] reports a residue mismatch; otherwise
//                        err[2] is tied low and no CRC logic is built.
// ---------------------------------------------------------------------------
module mac_rx #(
   parameter int MIN_PREAMBLE = 1,
   parameter int MIN_PAYLOAD  = 46,
   parameter int MAX_PAYLOAD  = 1500
) (
   input logic     in_clk,
   input logic     in_rst_n,
   mac_rx_if.slave bus
);

   localparam logic [7:0]  MIN_PRE = 8'(MIN_PREAMBLE);
   localparam logic [10:0] MIN_PAY = 11'(MIN_PAYLOAD);
   localparam logic [10:0] MAX_PAY = 11'(MAX_PAYLOAD);

   typedef enum logic [2:0] {
      IDLE, PREAMBLE, MACDEST, MACSRC, ETHERTYPE, PAYLOAD, DROP
   } state_t;

   state_t      state, state_nxt;
   logic        rxdv;
   logic [7:0]  rxd;
   logic [7:0]  pre_cnt;
   logic [2:0]  hdr_cnt;
   logic [7:0]  dly [4];      // dly[0] newest, dly[3] oldest
   logic [2:0]  dly_cnt;
   logic [10:0] pay_cnt;
   logic        long_flag;
   logic        fcs_bad;
   logic        rxen_r, hdr_valid_r, eof_r, ok_r;
   logic [7:0]  rxd_r;
   logic [2:0]  err_r;
   logic [47:0] dest_mac, src_mac;
   logic [15:0] ether_type;

   assign rxdv = bus.in_rxdv;
   assign rxd  = bus.in_rxd;

   assign bus.out_rxen       = rxen_r;
   assign bus.out_rxd        = rxd_r;
   assign bus.out_hdr_valid  = hdr_valid_r;
   assign bus.out_dest_mac   = dest_mac;
   assign bus.out_src_mac    = src_mac;
   assign bus.out_ether_type = ether_type;
   assign bus.out_eof        = eof_r;
   assign bus.out_frame_ok   = ok_r;
   assign bus.out_err        = err_r;

`ifdef MAC_RX_FCS_CHECK_EN
   logic [31:0] crc;

   // Reflected CRC-32, one byte, LSB first; no final inversion so that a
   // frame including its FCS leaves the fixed residue in the register.
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n)
         crc <= '0;
      else if (state == PREAMBLE && state_nxt == MACDEST)
         crc <= 32'hFFFFFFFF;
      else if (rxdv && (state == MACDEST || state == MACSRC ||
                        state == ETHERTYPE || state == PAYLOAD))
         crc <= crc_byte(crc, rxd);
   end

   assign fcs_bad = (crc != 32'hDEBB20E3);
`else
   assign fcs_bad = 1'b0;
`endif

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) state <= IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:
            if (rxdv) state_nxt = (rxd == 8'hAA) ? PREAMBLE : DROP;
         PREAMBLE:
            if (!rxdv)                                  state_nxt = IDLE;
            else if (rxd == 8'hAB && pre_cnt >= MIN_PRE) state_nxt = MACDEST;
            else if (rxd != 8'hAA)                       state_nxt = DROP;
         MACDEST:
            if (!rxdv)                state_nxt = IDLE;
            else if (hdr_cnt == 3'd5) state_nxt = MACSRC;
         MACSRC:
            if (!rxdv)                state_nxt = IDLE;
            else if (hdr_cnt == 3'd5) state_nxt = ETHERTYPE;
         ETHERTYPE:
            if (!rxdv)                state_nxt = IDLE;
            else if (hdr_cnt == 3'd1) state_nxt = PAYLOAD;
         PAYLOAD, DROP:
            if (!rxdv) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         pre_cnt     <= '0;
         hdr_cnt     <= '0;
         for (int i = 0; i < 4; i++) dly[i] <= '0;
         dly_cnt     <= '0;
         pay_cnt     <= '0;
         long_flag   <= 1'b0;
         rxen_r      <= 1'b0;
         rxd_r       <= '0;
         hdr_valid_r <= 1'b0;
         eof_r       <= 1'b0;
         ok_r        <= 1'b0;
         err_r       <= '0;
         dest_mac    <= '0;
         src_mac     <= '0;
         ether_type  <= '0;
      end else begin
         // Pulses and status are single-cycle unless re-asserted below.
         rxen_r      <= 1'b0;
         hdr_valid_r <= 1'b0;
         eof_r       <= 1'b0;
         ok_r        <= 1'b0;
         err_r       <= '0;
         case (state)
            IDLE:
               if (rxdv && rxd == 8'hAA) pre_cnt <= 8'd1;
            PREAMBLE:
               if (rxdv) begin
                  if (rxd == 8'hAA && pre_cnt != 8'hFF) pre_cnt <= pre_cnt + 8'd1;
                  hdr_cnt   <= '0;
                  dly_cnt   <= '0;
                  pay_cnt   <= '0;
                  long_flag <= 1'b0;
               end
            MACDEST, MACSRC, ETHERTYPE:
               if (!rxdv) begin
                  // Frame truncated inside the header: report as runt.
                  eof_r <= 1'b1;
                  err_r <= 3'b001;
               end else begin
                  if (state == MACDEST)      dest_mac   <= {dest_mac[39:0], rxd};
                  else if (state == MACSRC)  src_mac    <= {src_mac[39:0], rxd};
                  else                       ether_type <= {ether_type[7:0], rxd};
                  if ((state != ETHERTYPE && hdr_cnt == 3'd5) ||
                      (state == ETHERTYPE && hdr_cnt == 3'd1)) begin
                     hdr_cnt <= '0;
                     if (state == ETHERTYPE) hdr_valid_r <= 1'b1;
                  end else begin
                     hdr_cnt <= hdr_cnt + 3'd1;
                  end
               end
            PAYLOAD:
               if (rxdv) begin
                  // Only a byte pushed out of the full delay line can be payload;
                  // the last four bytes (FCS) never leave.
                  if (dly_cnt == 3'd4) begin
                     if (pay_cnt < MAX_PAY) begin
                        rxen_r <= 1'b1;
                        rxd_r  <= dly[3];
                     end else begin
                        long_flag <= 1'b1;
                     end
                     if (pay_cnt != 11'h7FF) pay_cnt <= pay_cnt + 11'd1;
                  end else begin
                     dly_cnt <= dly_cnt + 3'd1;
                  end
                  dly[3] <= dly[2];
                  dly[2] <= dly[1];
                  dly[1] <= dly[0];
                  dly[0] <= rxd;
               end else begin
                  eof_r    <= 1'b1;
                  err_r[0] <= (dly_cnt != 3'd4) || (pay_cnt < MIN_PAY);
                  err_r[1] <= long_flag;
                  err_r[2] <= fcs_bad;
                  ok_r     <= !((dly_cnt != 3'd4) || (pay_cnt < MIN_PAY) ||
                                long_flag || fcs_bad);
               end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_rx.sv
// ---------------------------------------------------------------------------
// tb_mac_rx : directed bench for mac_rx. A table of frame shapes is built,
// sent and checked in a loop; drop and mid-frame reset are hand sequences.
// ---------------------------------------------------------------------------
module tb_mac_rx;

   logic in_clk   = 1'b0;
   logic in_rst_n = 1'b0;

   mac_rx_if bus();

   mac_rx dut (
      .in_clk   (in_clk),
      .in_rst_n (in_rst_n),
      .bus      (bus)
   );

   always #5 in_clk = ~in_clk;

`ifdef MAC_RX_FCS_CHECK_EN
   localparam logic [2:0] FLIP_ERR = 3'b100;
`else
   localparam logic [2:0] FLIP_ERR = 3'b000;
`endif

   typedef struct {
      string      name;
      int         pay_len;
      int         flip_idx;
      int         exp_beats;
      logic [2:0] exp_err;
   } vec_t;

   vec_t        vecs [4];
   logic [7:0]  tx_q  [$];
   logic [7:0]  exp_q [$];
   logic [7:0]  got_q [$];
   int          hdr_seen, eof_seen;
   logic [47:0] cap_dest, cap_src;
   logic [15:0] cap_type;
   logic [2:0]  cap_err;
   logic        cap_ok;
   int          n_pass  = 0;
   int          n_total = 0;

   // Output monitor, sampled mid-cycle.
   always @(negedge in_clk) begin
      if (in_rst_n) begin
         if (bus.out_rxen) got_q.push_back(bus.out_rxd);
         if (bus.out_hdr_valid) begin
            hdr_seen++;
            cap_dest = bus.out_dest_mac;
            cap_src  = bus.out_src_mac;
            cap_type = bus.out_ether_type;
         end
         if (bus.out_eof) begin
            eof_seen++;
            cap_err = bus.out_err;
            cap_ok  = bus.out_frame_ok;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else
         n_pass++;
   endtask

   // Standard Ethernet FCS generator (inverted CRC, sent low byte first).
   function automatic logic [31:0] fcs_step(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int k = 0; k < 8; k++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   task automatic build_frame(input int pay_len, input int flip_idx);
      logic [31:0] c;
      logic [7:0]  b;
      tx_q.delete();
      exp_q.delete();
      repeat (7) tx_q.push_back(8'hAA);
      tx_q.push_back(8'hAB);
      c = 32'hFFFFFFFF;
      for (int i = 1; i <= 6; i++) begin
         b = 8'(i);
         tx_q.push_back(b);
         c = fcs_step(c, b);
      end
      for (int i = 1; i <= 6; i++) begin
         b = 8'h10 + 8'(i);
         tx_q.push_back(b);
         c = fcs_step(c, b);
      end
      b = 8'h08; tx_q.push_back(b); c = fcs_step(c, b);
      b = 8'h00; tx_q.push_back(b); c = fcs_step(c, b);
      for (int i = 0; i < pay_len; i++) begin
         b = 8'(i);
         c = fcs_step(c, b);
         if (i == flip_idx) b = ~b;
         tx_q.push_back(b);
         if (i < 1500) exp_q.push_back(b);
      end
      c = ~c;
      tx_q.push_back(c[7:0]);
      tx_q.push_back(c[15:8]);
      tx_q.push_back(c[23:16]);
      tx_q.push_back(c[31:24]);
   endtask

   task automatic clear_mon();
      got_q.delete();
      hdr_seen = 0;
      eof_seen = 0;
      cap_dest = '0;
      cap_src  = '0;
      cap_type = '0;
      cap_err  = 3'b111;
      cap_ok   = 1'bx;
   endtask

   task automatic send_frame();
      foreach (tx_q[i]) begin
         @(negedge in_clk);
         bus.in_rxdv = 1'b1;
         bus.in_rxd  = tx_q[i];
      end
      @(negedge in_clk);
      bus.in_rxdv = 1'b0;
      bus.in_rxd  = 8'h00;
      repeat (4) @(negedge in_clk);
   endtask

   task automatic check_frame(input string nm, input int exp_beats, input logic [2:0] exp_err);
      int mism;
      mism = 0;
      for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
         if (got_q[k] !== exp_q[k]) mism++;
      chk({nm, " hdr_pulses"}, hdr_seen, 1);
      chk({nm, " dest_mac"}, cap_dest, 48'h010203040506);
      chk({nm, " src_mac"}, cap_src, 48'h111213141516);
      chk({nm, " ether_type"}, cap_type, 16'h0800);
      chk({nm, " beats"}, got_q.size(), exp_beats);
      chk({nm, " data_mismatches"}, mism, 0);
      chk({nm, " eof_pulses"}, eof_seen, 1);
      chk({nm, " err"}, cap_err, exp_err);
      chk({nm, " frame_ok"}, cap_ok, (exp_err == 3'b000));
   endtask

   initial begin
      vecs[0] = '{name: "basic",    pay_len: 46,   flip_idx: -1, exp_beats: 46,   exp_err: 3'b000};
      vecs[1] = '{name: "fcs_flip", pay_len: 46,   flip_idx: 16, exp_beats: 46,   exp_err: FLIP_ERR};
      vecs[2] = '{name: "short",    pay_len: 20,   flip_idx: -1, exp_beats: 20,   exp_err: 3'b001};
      vecs[3] = '{name: "long",     pay_len: 1501, flip_idx: -1, exp_beats: 1500, exp_err: 3'b010};

      bus.in_rxdv = 1'b0;
      bus.in_rxd  = 8'h00;
      clear_mon();

      // Reset state.
      #12;
      chk("reset ctrl_outs",
          {bus.out_rxen, bus.out_rxd, bus.out_hdr_valid, bus.out_eof, bus.out_frame_ok, bus.out_err}, 0);
      chk("reset hdr_regs", {bus.out_dest_mac, bus.out_src_mac} | 96'(bus.out_ether_type), 0);
      @(negedge in_clk);
      in_rst_n = 1'b1;
      repeat (2) @(negedge in_clk);

      foreach (vecs[v]) begin
         build_frame(vecs[v].pay_len, vecs[v].flip_idx);
         clear_mon();
         send_frame();
         check_frame(vecs[v].name, vecs[v].exp_beats, vecs[v].exp_err);
      end

      // Bad preamble: frame dropped silently, then a good frame.
      build_frame(46, -1);
      tx_q[1] = 8'h55;
      clear_mon();
      send_frame();
      chk("drop hdr_pulses", hdr_seen, 0);
      chk("drop beats", got_q.size(), 0);
      chk("drop eof_pulses", eof_seen, 0);
      build_frame(46, -1);
      clear_mon();
      send_frame();
      check_frame("after_drop", 46, 3'b000);

      // Reset asserted while payload byte 20 is on the bus.
      build_frame(46, -1);
      clear_mon();
      foreach (tx_q[i]) begin
         @(negedge in_clk);
         bus.in_rxdv = 1'b1;
         bus.in_rxd  = tx_q[i];
         if (i == 8 + 14 + 20) break;
      end
      #2 in_rst_n = 1'b0;
      #1;
      chk("midreset ctrl_outs",
          {bus.out_rxen, bus.out_rxd, bus.out_hdr_valid, bus.out_eof, bus.out_frame_ok, bus.out_err}, 0);
      chk("midreset hdr_regs", {bus.out_dest_mac, bus.out_src_mac} | 96'(bus.out_ether_type), 0);
      @(negedge in_clk);
      bus.in_rxdv = 1'b0;
      bus.in_rxd  = 8'h00;
      repeat (2) @(negedge in_clk);
      in_rst_n = 1'b1;
      repeat (3) @(negedge in_clk);
      chk("midreset eof_pulses", eof_seen, 0);
      clear_mon();
      send_frame();
      check_frame("after_reset", 46, 3'b000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
